// File: rtl/exmem_reg_if.sv
// rtl/exmem_reg_if.sv - EX/MEM latch bundle: pipeline fields, hazard strobes and data-cache handshake
interface exmem_reg_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
);
  logic              enable;
  logic              flush;
  logic [WORD_W-1:0] aluout_i;
  logic [WORD_W-1:0] rdat2_i;
  logic [WORD_W-1:0] npc_i;
  logic [WORD_W-1:0] extout_i;
  logic [REG_W-1:0]  wsel_i;
  logic              RegW_i;
  logic              DRen_i;
  logic              DWen_i;
  logic              halt_i;
  logic [1:0]        Mem_i;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  logic [WORD_W-1:0] aluout_o;
  logic [WORD_W-1:0] rdat2_o;
  logic [WORD_W-1:0] npc_o;
  logic [WORD_W-1:0] extout_o;
  logic [REG_W-1:0]  wsel_o;
  logic              RegW_o;
  logic              DRen_o;
  logic              DWen_o;
  logic              halt_o;
  logic [1:0]        Mem_o;
  logic [WORD_W-1:0] dload_o;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              mem_stall_o;

  modport slave (
    input  enable, flush, aluout_i, rdat2_i, npc_i, extout_i, wsel_i,
           RegW_i, DRen_i, DWen_i, halt_i, Mem_i, dhit, dmemload,
    output aluout_o, rdat2_o, npc_o, extout_o, wsel_o, RegW_o, DRen_o,
           DWen_o, halt_o, Mem_o, dload_o, dmemREN, dmemWEN, dmemaddr,
           dmemstore, mem_stall_o
  );

  modport master (
    output enable, flush, aluout_i, rdat2_i, npc_i, extout_i, wsel_i,
           RegW_i, DRen_i, DWen_i, halt_i, Mem_i, dhit, dmemload,
    input  aluout_o, rdat2_o, npc_o, extout_o, wsel_o, RegW_o, DRen_o,
           DWen_o, halt_o, Mem_o, dload_o, dmemREN, dmemWEN, dmemaddr,
           dmemstore, mem_stall_o
  );
endinterface

// File: rtl/exmem_reg.sv
// rtl/exmem_reg.sv - EX/MEM pipeline register owning the one-shot data-memory request
module exmem_reg #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic        CLK,
  input  logic        nRST,
  exmem_reg_if.slave  bus
);

  logic [WORD_W-1:0] r_aluout;
  logic [WORD_W-1:0] r_rdat2;
  logic [WORD_W-1:0] r_npc;
  logic [WORD_W-1:0] r_extout;
  logic [REG_W-1:0]  r_wsel;
  logic              r_regw;
  logic              r_dren;
  logic              r_dwen;
  logic              r_halt;
  logic [1:0]        r_mem;
  logic [WORD_W-1:0] r_dload;
  logic              r_served;

  logic              w_mem_op;
  logic              w_dmemren;
  logic              w_dmemwen;

  assign w_mem_op  = r_dren | r_dwen;
  assign w_dmemren = r_dren & ~r_served;
  assign w_dmemwen = r_dwen & ~r_served;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_aluout <= '0;
      r_rdat2  <= '0;
      r_npc    <= '0;
      r_extout <= '0;
      r_wsel   <= '0;
      r_regw   <= 1'b0;
      r_dren   <= 1'b0;
      r_dwen   <= 1'b0;
      r_halt   <= 1'b0;
      r_mem    <= 2'b00;
      r_served <= 1'b0;
    end else if (bus.enable) begin
      r_served <= 1'b0;
      if (bus.flush) begin
        // Bubble: halt survives so a halted pipe cannot be restarted by a flush
        r_aluout <= '0;
        r_rdat2  <= '0;
        r_npc    <= '0;
        r_extout <= '0;
        r_wsel   <= '0;
        r_regw   <= 1'b0;
        r_dren   <= 1'b0;
        r_dwen   <= 1'b0;
        r_mem    <= 2'b00;
      end else begin
        r_aluout <= bus.aluout_i;
        r_rdat2  <= bus.rdat2_i;
        r_npc    <= bus.npc_i;
        r_extout <= bus.extout_i;
        r_wsel   <= bus.wsel_i;
        r_regw   <= bus.RegW_i;
        r_dren   <= bus.DRen_i;
        r_dwen   <= bus.DWen_i;
        r_halt   <= r_halt | bus.halt_i;
        r_mem    <= bus.Mem_i;
      end
    end else if (bus.dhit && w_mem_op) begin
      r_served <= 1'b1;
    end
  end

  // Load word is independent of enable/flush so MEM/WB can still sample it after the advance edge
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dload <= '0;
    end else if (bus.dhit && w_dmemren) begin
      r_dload <= bus.dmemload;
    end
  end

  assign bus.aluout_o    = r_aluout;
  assign bus.rdat2_o     = r_rdat2;
  assign bus.npc_o       = r_npc;
  assign bus.extout_o    = r_extout;
  assign bus.wsel_o      = r_wsel;
  assign bus.RegW_o      = r_regw;
  assign bus.DRen_o      = r_dren;
  assign bus.DWen_o      = r_dwen;
  assign bus.halt_o      = r_halt;
  assign bus.Mem_o       = r_mem;
  assign bus.dload_o     = r_dload;
  assign bus.dmemREN     = w_dmemren;
  assign bus.dmemWEN     = w_dmemwen;
  assign bus.dmemaddr    = r_aluout;
  assign bus.dmemstore   = r_rdat2;
  assign bus.mem_stall_o = w_mem_op & ~r_served & ~bus.dhit;

endmodule
